// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// RV32I decode pipeline stage between fetch and execute. Each accepted
// instruction is decoded combinationally and stored in a two-entry skid
// buffer. The buffer drives the execute side directly from its head slot.
// Both sides use a valid/ready handshake. in_ready comes from a register and
// does not depend on out_ready, so the path from execute back to fetch has no
// combinational loop.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//    defined   - adds the out_illegal port. An illegal bundle keeps its raw
//                fields, and its reg_we is forced to 0.
//    undefined - an illegal instruction is replaced by the decode of NOP_INSTR.
//
// Ports
//    clk, rst        rising-edge clock, synchronous active-high reset
//    flush           discard every buffered entry and any push in the same cycle
//    in_valid        fetch presents in_instr / in_pc
//    in_ready        stage can accept (registered)
//    in_instr        raw 32-bit instruction
//    in_pc           instruction address
//    out_valid       decoded bundle valid (held until out_ready)
//    out_ready       execute accepts the bundle
//    out_op          {funct7, funct3, opcode} ALU op bus
//    out_imm         sign-extended immediate
//    out_rs1/rs2/rd  raw register index fields
//    out_use_imm     ALU b operand is the immediate
//    out_reg_we      instruction writes rd (0 when rd is x0)
//    out_pc          PC passed through
//    out_illegal     illegal-instruction flag (only with DECODE_ILLEGAL_TRAP_EN)
// ---------------------------------------------------------------------------
module decode_stage #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [16:0]     out_op,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic            out_use_imm,
   output logic            out_reg_we,
   output logic [XLEN-1:0] out_pc
`ifdef DECODE_ILLEGAL_TRAP_EN
   ,
   output logic            out_illegal
`endif
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef struct packed {
      logic [16:0]     op;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            useImm;
      logic            regWe;
      logic [XLEN-1:0] pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
      logic            illegal;
`endif
   } bundle_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   occ_t    state_q;
   bundle_t head_q;
   bundle_t tail_q;
   logic    inReady_q;
   logic    outValid_q;
   bundle_t decoded;
   logic    push;
   logic    pop;

   // An instruction is illegal if its opcode is not recognised. It is also
   // illegal if it is an R-type with an unsupported funct7, or with the
   // alternate funct7 (0100000) on any funct3 other than SUB/SRA.
   function automatic logic instrIllegal(input logic [31:0] instr);
      logic       illegal;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      opc = instr[6:0];
      f3  = instr[14:12];
      f7  = instr[31:25];
      case (opc)
         OPC_OP:
            illegal = !((f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
         OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE,
         OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL:
            illegal = 1'b0;
         default:
            illegal = 1'b1;
      endcase
      return illegal;
   endfunction

   // Field extraction. Only R-type and the immediate shifts carry funct7 on
   // the op bus. A shift immediate is the unsigned shamt field. Every other
   // immediate is assembled as 32 bits and then sign-extended to XLEN.
   function automatic bundle_t decodeInstr(input logic [31:0] instr,
                                           input logic [XLEN-1:0] pc);
      bundle_t    b;
      logic [6:0] opc;
      logic [2:0] f3;
      logic       isShift;
      logic [31:0] imm32;
      b       = '0;
      opc     = instr[6:0];
      f3      = instr[14:12];
      isShift = (opc == OPC_OPIMM) && ((f3 == 3'b001) || (f3 == 3'b101));
      b.op    = {((opc == OPC_OP) || isShift) ? instr[31:25] : 7'b0, f3, opc};
      case (opc)
         OPC_OPIMM:
            imm32 = isShift ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
         OPC_LOAD, OPC_JALR:
            imm32 = {{20{instr[31]}}, instr[31:20]};
         OPC_STORE:
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BRANCH:
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm32 = {instr[31:12], 12'b0};
         OPC_JAL:
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm32 = 32'b0;
      endcase
      b.imm    = XLEN'($signed(imm32));
      b.rs1    = instr[19:15];
      b.rs2    = instr[24:20];
      b.rd     = instr[11:7];
      b.useImm = !((opc == OPC_OP) || (opc == OPC_BRANCH));
      case (opc)
         OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_JAL:
            b.regWe = (instr[11:7] != 5'd0);
         default:
            b.regWe = 1'b0;
      endcase
      b.pc = pc;
      return b;
   endfunction

   // Combinational decode of the incoming instruction. The illegal-instruction
   // policy (flag it, or replace it with a NOP) is chosen at build time.
   always_comb begin
      decoded = decodeInstr(in_instr, in_pc);
`ifdef DECODE_ILLEGAL_TRAP_EN
      decoded.illegal = instrIllegal(in_instr);
      if (decoded.illegal) begin
         decoded.regWe = 1'b0;
      end
`else
      if (instrIllegal(in_instr)) begin
         decoded = decodeInstr(NOP_INSTR, in_pc);
      end
`endif
   end

   assign push = in_valid && inReady_q;
   assign pop  = outValid_q && out_ready;

   // Occupancy FSM for the skid buffer. head_q is always the oldest entry
   // and feeds the outputs directly. tail_q holds the entry that was caught
   // while execute stalled. A push is impossible in TWO because in_ready
   // is low there. Flush empties the buffer and drops any same-cycle push.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         head_q     <= '0;
         tail_q     <= '0;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
      end else if (flush) begin
         state_q    <= EMPTY;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  head_q     <= decoded;
                  state_q    <= ONE;
                  outValid_q <= 1'b1;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head_q <= decoded;
               end else if (push) begin
                  tail_q    <= decoded;
                  state_q   <= TWO;
                  inReady_q <= 1'b0;
               end else if (pop) begin
                  state_q    <= EMPTY;
                  outValid_q <= 1'b0;
               end
            end
            TWO: begin
               if (pop) begin
                  head_q    <= tail_q;
                  state_q   <= ONE;
                  inReady_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= EMPTY;
               inReady_q  <= 1'b1;
               outValid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = inReady_q;
   assign out_valid   = outValid_q;
   assign out_op      = head_q.op;
   assign out_imm     = head_q.imm;
   assign out_rs1     = head_q.rs1;
   assign out_rs2     = head_q.rs2;
   assign out_rd      = head_q.rd;
   assign out_use_imm = head_q.useImm;
   assign out_reg_we  = head_q.regWe;
   assign out_pc      = head_q.pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
   assign out_illegal = head_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Bench for decode_stage. It applies directed cases (the reference
// instructions, backpressure, flush, the all-zero instruction and a reset
// mid-stream), then randomized traffic. A queue-based reference model
// predicts occupancy and the head bundle. It decodes each instruction from
// the RV32I field rules using plain shifts and masks.
// ---------------------------------------------------------------------------
module tb_decode_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] out_op;
   logic [31:0] out_imm;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic        out_use_imm;
   logic        out_reg_we;
   logic [31:0] out_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic        out_illegal;
`endif

   typedef struct {
      logic [16:0] op;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        useImm;
      logic        regWe;
      logic [31:0] pc;
      logic        illegal;
   } exp_t;

   exp_t sb[$];
   int   nVectors     = 0;
   int   nMiscompares = 0;

   decode_stage #(.XLEN(32), .NOP_INSTR(32'h00000013)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_op      (out_op),
      .out_imm     (out_imm),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_rd      (out_rd),
      .out_use_imm (out_use_imm),
      .out_reg_we  (out_reg_we),
      .out_pc      (out_pc)
`ifdef DECODE_ILLEGAL_TRAP_EN
      ,
      .out_illegal (out_illegal)
`endif
   );

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   // True when the instruction is not one the stage supports
   function automatic logic isBad(input logic [31:0] instr);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       known;
      opc   = instr[6:0];
      f3    = instr[14:12];
      f7    = instr[31:25];
      known = (opc == 7'h33) || (opc == 7'h13) || (opc == 7'h03) || (opc == 7'h67) ||
              (opc == 7'h23) || (opc == 7'h63) || (opc == 7'h37) || (opc == 7'h17) ||
              (opc == 7'h6F);
      if (!known) return 1'b1;
      if (opc == 7'h33) return !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      return 1'b0;
   endfunction

   // Reference decode built from field rules with arithmetic shifts and masks
   function automatic exp_t refDecode(input logic [31:0] raw, input logic [31:0] pc);
      exp_t               e;
      logic [31:0]        instr;
      logic signed [31:0] sx;
      logic [31:0]        hi20;
      logic [31:0]        hi25;
      logic [31:0]        sgn;
      logic [6:0]         opc;
      logic [2:0]         f3;
      logic               isR, isI, isLoad, isJalr, isS, isB, isU, isJ, shift, bad;
      bad   = isBad(raw);
      instr = raw;
`ifndef DECODE_ILLEGAL_TRAP_EN
      if (bad) instr = 32'h00000013;
`endif
      opc    = instr[6:0];
      f3     = instr[14:12];
      isR    = (opc == 7'h33);
      isI    = (opc == 7'h13);
      isLoad = (opc == 7'h03);
      isJalr = (opc == 7'h67);
      isS    = (opc == 7'h23);
      isB    = (opc == 7'h63);
      isU    = (opc == 7'h37) || (opc == 7'h17);
      isJ    = (opc == 7'h6F);
      shift  = isI && ((f3 == 3'd1) || (f3 == 3'd5));
      sx     = $signed(instr);
      hi20   = sx >>> 20;
      hi25   = sx >>> 25;
      sgn    = sx >>> 31;
      e.op   = {(isR || shift) ? instr[31:25] : 7'd0, f3, opc};
      if (shift)                         e.imm = 32'(instr[24:20]);
      else if (isI || isLoad || isJalr)  e.imm = hi20;
      else if (isS)                      e.imm = (hi25 << 5) | 32'(instr[11:7]);
      else if (isB)                      e.imm = (sgn << 12) | (32'(instr[7]) << 11) |
                                                 (32'(instr[30:25]) << 5) | (32'(instr[11:8]) << 1);
      else if (isU)                      e.imm = instr & 32'hFFFFF000;
      else if (isJ)                      e.imm = (sgn << 20) | (32'(instr[19:12]) << 12) |
                                                 (32'(instr[20]) << 11) | (32'(instr[30:21]) << 1);
      else                               e.imm = 32'd0;
      e.rs1     = instr[19:15];
      e.rs2     = instr[24:20];
      e.rd      = instr[11:7];
      e.useImm  = !(isR || isB);
      e.regWe   = (isR || isI || isLoad || isJalr || isU || isJ) && (instr[11:7] != 5'd0) && !bad;
      e.pc      = pc;
      e.illegal = bad;
      return e;
   endfunction

   // One comparison; a miss is counted and reported
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nVectors++;
      assert (observed === expected)
      else begin
         nMiscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Compare handshake flags and the head bundle against the model
   task automatic checkModel();
      exp_t h;
      checkOutput("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      checkOutput("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      if (sb.size() != 0) begin
         h = sb[0];
         checkOutput("op", 32'(out_op), 32'(h.op));
         checkOutput("imm", out_imm, h.imm);
         checkOutput("rs1", 32'(out_rs1), 32'(h.rs1));
         checkOutput("rs2", 32'(out_rs2), 32'(h.rs2));
         checkOutput("rd", 32'(out_rd), 32'(h.rd));
         checkOutput("use_imm", 32'(out_use_imm), 32'(h.useImm));
         checkOutput("reg_we", 32'(out_reg_we), 32'(h.regWe));
         checkOutput("pc", out_pc, h.pc);
`ifdef DECODE_ILLEGAL_TRAP_EN
         checkOutput("illegal", 32'(out_illegal), 32'(h.illegal));
`endif
      end
   endtask

   // Drive one cycle from a falling edge, advance the model, then check
   task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                input logic rdy, input logic fl);
      logic doPop;
      logic doPush;
      in_valid  = v;
      in_instr  = instr;
      in_pc     = pc;
      out_ready = rdy;
      flush     = fl;
      if (fl) begin
         sb.delete();
      end else begin
         doPop  = (sb.size() != 0) && rdy;
         doPush = v && (sb.size() < 2);
         if (doPop) sb.delete(0);
         if (doPush) sb.push_back(refDecode(instr, pc));
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      checkModel();
   endtask

   // Reset for one edge while fetch keeps offering data, then expect zeros
   task automatic resetAndCheck();
      rst      = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_op", 32'(out_op), 32'd0);
      checkOutput("rst_imm", out_imm, 32'd0);
      checkOutput("rst_regs", 32'({out_rs1, out_rs2, out_rd}), 32'd0);
      checkOutput("rst_flags", 32'({out_use_imm, out_reg_we}), 32'd0);
      checkOutput("rst_pc", out_pc, 32'd0);
   endtask

   // Random instruction that is mostly legal, with some illegal encodings mixed in
   function automatic logic [31:0] genInstr();
      logic [6:0]  opcList [9];
      logic [31:0] instr;
      logic [6:0]  opc;
      int          k;
      opcList = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
      k       = $urandom_range(0, 10);
      opc     = (k < 9) ? opcList[k] : 7'($urandom);
      instr   = $urandom;
      instr[6:0] = opc;
      if (opc == 7'h33) begin
         case ($urandom_range(0, 2))
            0:       instr[31:25] = 7'h00;
            1:       instr[31:25] = 7'h20;
            default: instr[31:25] = 7'($urandom);
         endcase
      end
      if ((opc == 7'h13) && ((instr[14:12] == 3'd1) || (instr[14:12] == 3'd5))) begin
         instr[31:25] = ((instr[14:12] == 3'd5) && ($urandom_range(0, 1) == 1)) ? 7'h20 : 7'h00;
      end
      if ($urandom_range(0, 7) == 0) instr[11:7] = 5'd0;
      return instr;
   endfunction

   // Directed sequence followed by randomized traffic
   initial begin
      clk       = 1'b0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'd0;
      in_pc     = 32'd0;
      out_ready = 1'b0;
      @(negedge clk);
      resetAndCheck();

      // Reference instructions with execute always ready
      applyStimulus(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0);
      checkOutput("add_op", 32'(out_op), 32'h00033);
      checkOutput("add_rs1", 32'(out_rs1), 32'd1);
      checkOutput("add_rs2", 32'(out_rs2), 32'd2);
      checkOutput("add_rd", 32'(out_rd), 32'd3);
      checkOutput("add_use_imm", 32'(out_use_imm), 32'd0);
      checkOutput("add_reg_we", 32'(out_reg_we), 32'd1);
      applyStimulus(1'b1, 32'h407302B3, 32'h104, 1'b1, 1'b0);
      checkOutput("sub_op", 32'(out_op), 32'h08033);
      checkOutput("sub_rd", 32'(out_rd), 32'd5);
      applyStimulus(1'b1, 32'hFFF00093, 32'h108, 1'b1, 1'b0);
      checkOutput("addi_op", 32'(out_op), 32'h00013);
      checkOutput("addi_imm", out_imm, 32'hFFFFFFFF);
      checkOutput("addi_use_imm", 32'(out_use_imm), 32'd1);
      applyStimulus(1'b1, 32'h0020A423, 32'h10C, 1'b1, 1'b0);
      checkOutput("sw_op", 32'(out_op), 32'h00123);
      checkOutput("sw_imm", out_imm, 32'd8);
      checkOutput("sw_reg_we", 32'(out_reg_we), 32'd0);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

      // Backpressure: three back-to-back pushes, third one held
      applyStimulus(1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b0);
      checkOutput("bp_ready1", 32'(in_ready), 32'd1);
      applyStimulus(1'b1, 32'h407302B3, 32'h204, 1'b0, 1'b0);
      checkOutput("bp_ready2", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 32'hFFF00093, 32'h208, 1'b0, 1'b0);
      checkOutput("bp_hold_pc", out_pc, 32'h200);
      applyStimulus(1'b1, 32'hFFF00093, 32'h208, 1'b1, 1'b0);
      checkOutput("bp_pc2", out_pc, 32'h204);
      applyStimulus(1'b1, 32'hFFF00093, 32'h208, 1'b1, 1'b0);
      checkOutput("bp_pc3", out_pc, 32'h208);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      checkOutput("bp_drained", 32'(out_valid), 32'd0);

      // Flush while full with a push offered, then flush with a push in ONE
      applyStimulus(1'b1, 32'h002081B3, 32'h300, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h407302B3, 32'h304, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0020A423, 32'h308, 1'b0, 1'b1);
      checkOutput("flush2_valid", 32'(out_valid), 32'd0);
      checkOutput("flush2_ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      checkOutput("flush2_gone", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 32'h002081B3, 32'h400, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0020A423, 32'h404, 1'b1, 1'b1);
      checkOutput("flush1_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      checkOutput("flush1_gone", 32'(out_valid), 32'd0);

      // All-zero instruction is illegal
      applyStimulus(1'b1, 32'h00000000, 32'h500, 1'b1, 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
      checkOutput("zero_illegal", 32'(out_illegal), 32'd1);
`else
      checkOutput("zero_op", 32'(out_op), 32'h00013);
      checkOutput("zero_imm", out_imm, 32'd0);
`endif
      checkOutput("zero_reg_we", 32'(out_reg_we), 32'd0);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

      // Reset mid-stream with a full buffer
      applyStimulus(1'b1, 32'h002081B3, 32'h600, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hFFF00093, 32'h604, 1'b0, 1'b0);
      resetAndCheck();

      // Randomized traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), genInstr(), 32'(i * 4 + 32'h1000),
                       ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
